// File: rtl/regfile_scanner_if.sv
// Valid/ready stream of {address, data} pairs
// leaving the register-file scanner.
interface regfile_scanner_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic               outValid;
  logic               outReady;
  logic [REGBITS-1:0] outAddr;
  logic [WIDTH-1:0]   outData;

  modport master (
    output outValid,
    output outAddr,
    output outData,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outAddr,
    input  outData,
    output outReady
  );
endinterface

// File: rtl/regfile_scanner.sv
// Walks a register range on the read port and
// streams {address, data} pairs downstream.
module regfile_scanner #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [REGBITS-1:0] firstAddr,
  input  logic [REGBITS-1:0] lastAddr,
  output logic [REGBITS-1:0] srcAddr,
  input  logic [WIDTH-1:0]   readData,
  regfile_scanner_if.master  out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [REGBITS-1:0] cur_q, cur_d;
  logic [REGBITS-1:0] end_q, end_d;
  logic               valid_q, valid_d;
  logic [REGBITS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]   data_q, data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = firstAddr;
          end_d   = lastAddr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        data_d  = readData;
        addr_d  = cur_q;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && out.outReady) begin
          valid_d = 1'b0;
          if (cur_q == end_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + REGBITS'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cur_q holds its last value in IDLE, so srcAddr does too
  always_comb begin
    srcAddr      = cur_q;
    out.outValid = valid_q;
    out.outAddr  = addr_q;
    out.outData  = data_q;
    busy = (state_q == S_FETCH)
        || (state_q == S_SEND);
    done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed bench for regfile_scanner: ranges,
// wrap, backpressure, ignored start, reset.
module tb_regfile_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  first_addr = '0;
  logic [3:0]  last_addr = '0;
  logic [3:0]  src_addr;
  logic [15:0] read_data;
  logic        busy;
  logic        done;
  logic [15:0] rf [16];

  int passed = 0;
  int total  = 0;

  logic [3:0]  got_a [$];
  logic [15:0] got_d [$];

  regfile_scanner_if #(.WIDTH(16), .REGBITS(4)) bus ();

  always #5 clk = ~clk;

  assign read_data = rf[src_addr];

  regfile_scanner #(.WIDTH(16), .REGBITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .firstAddr (first_addr),
    .lastAddr  (last_addr),
    .srcAddr   (src_addr),
    .readData  (read_data),
    .out       (bus),
    .busy      (busy),
    .done      (done)
  );

  // cycle 0 = cycle start is driven; returns when done seen
  task automatic scan(
    input  logic [3:0] f,
    input  logic [3:0] l,
    input  int         poke,
    output int         n,
    output int         done_cyc
  );
    got_a.delete();
    got_d.delete();
    done_cyc = -1;
    @(posedge clk); #1;
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (bus.outValid && bus.outReady) begin
        got_a.push_back(bus.outAddr);
        got_d.push_back(bus.outData);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      start = (c == poke);
      if (c == poke) begin
        first_addr = 4'd9;
        last_addr = 4'd9;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n = got_a.size();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (src_addr !== 4'd0)
      $display("FAIL rst_src got %h want 0", src_addr);
    else passed++;
    total++;
    if ({bus.outValid, busy, done} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
        {bus.outValid, busy, done});
    else passed++;
    total++;
    if ({bus.outAddr, bus.outData} !== 20'h0)
      $display("FAIL rst_pair got %h want 0",
        {bus.outAddr, bus.outData});
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_full();
    int n, dc;
    scan(4'd0, 4'd15, 0, n, dc);
    total++;
    if (n !== 16) $display("FAIL full_n got %0d want 16", n);
    else passed++;
    for (int i = 0; i < n && i < 16; i++) begin
      total++;
      if (got_a[i] !== 4'(i) || got_d[i] !== 16'hA000 + 16'(i))
        $display("FAIL full_pair%0d got %h/%h want %h/%h", i,
          got_a[i], got_d[i], 4'(i), 16'hA000 + 16'(i));
      else passed++;
    end
    total++;
    if (dc !== 33) $display("FAIL full_done got %0d want 33", dc);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL full_busy got %b want 0", busy);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) $display("FAIL full_pulse got %b want 0", done);
    else passed++;
  endtask

  task automatic test_wrap();
    int n, dc;
    logic [3:0] ea [4];
    ea = '{4'd14, 4'd15, 4'd0, 4'd1};
    scan(4'd14, 4'd1, 0, n, dc);
    total++;
    if (n !== 4) $display("FAIL wrap_n got %0d want 4", n);
    else passed++;
    for (int i = 0; i < n && i < 4; i++) begin
      total++;
      if (got_a[i] !== ea[i] || got_d[i] !== 16'hA000 + 16'(ea[i]))
        $display("FAIL wrap_pair%0d got %h/%h want %h/%h", i,
          got_a[i], got_d[i], ea[i], 16'hA000 + 16'(ea[i]));
      else passed++;
    end
    total++;
    if (dc !== 9) $display("FAIL wrap_done got %0d want 9", dc);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) $display("FAIL wrap_pulse got %b want 0", done);
    else passed++;
  endtask

  task automatic test_single();
    int n, dc;
    scan(4'd7, 4'd7, 0, n, dc);
    total++;
    if (n !== 1) $display("FAIL single_n got %0d want 1", n);
    else passed++;
    if (n > 0) begin
      total++;
      if (got_a[0] !== 4'd7 || got_d[0] !== 16'hA007)
        $display("FAIL single_pair got %h/%h want 7/a007",
          got_a[0], got_d[0]);
      else passed++;
    end
    total++;
    if (dc !== 3) $display("FAIL single_done got %0d want 3", dc);
    else passed++;
  endtask

  task automatic test_backpressure();
    int t;
    logic stable;
    logic [3:0] ea;
    bus.outReady = 1'b0;
    @(posedge clk); #1;
    first_addr = 4'd2;
    last_addr = 4'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ea = 4'(2 + k);
      t = 0;
      while (!bus.outValid && t < 10) begin
        @(posedge clk); #1;
        t++;
      end
      total++;
      if (bus.outValid !== 1'b1 || bus.outAddr !== ea
          || bus.outData !== 16'hA000 + 16'(ea))
        $display("FAIL bp_pair%0d got %b %h/%h want 1 %h/%h", k,
          bus.outValid, bus.outAddr, bus.outData,
          ea, 16'hA000 + 16'(ea));
      else passed++;
      stable = 1'b1;
      for (int s = 0; s < 5; s++) begin
        @(posedge clk); #1;
        if (bus.outValid !== 1'b1 || bus.outAddr !== ea
            || bus.outData !== 16'hA000 + 16'(ea)
            || src_addr !== ea)
          stable = 1'b0;
      end
      total++;
      if (stable !== 1'b1)
        $display("FAIL bp_stall%0d got unstable want stable", k);
      else passed++;
      bus.outReady = 1'b1;
      @(posedge clk); #1;
      bus.outReady = 1'b0;
      total++;
      if (bus.outValid !== 1'b0)
        $display("FAIL bp_accept%0d got %b want 0", k, bus.outValid);
      else passed++;
    end
    total++;
    if ({done, busy} !== 2'b10)
      $display("FAIL bp_done got %b want 10", {done, busy});
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({done, bus.outValid} !== 2'b00)
      $display("FAIL bp_idle got %b want 00", {done, bus.outValid});
    else passed++;
  endtask

  task automatic test_start_busy();
    int n, dc;
    logic extra;
    scan(4'd0, 4'd3, 3, n, dc);
    total++;
    if (n !== 4) $display("FAIL sb_n got %0d want 4", n);
    else passed++;
    for (int i = 0; i < n && i < 4; i++) begin
      total++;
      if (got_a[i] !== 4'(i) || got_d[i] !== 16'hA000 + 16'(i))
        $display("FAIL sb_pair%0d got %h/%h want %h/%h", i,
          got_a[i], got_d[i], 4'(i), 16'hA000 + 16'(i));
      else passed++;
    end
    total++;
    if (dc !== 9) $display("FAIL sb_done got %0d want 9", dc);
    else passed++;
    extra = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (busy || bus.outValid || done) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) $display("FAIL sb_idle got activity want none");
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n, dc;
    logic found;
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    first_addr = 4'd0;
    last_addr = 4'd15;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.outValid && bus.outAddr == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (found !== 1'b1) $display("FAIL rm_reach got 0 want 1");
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (src_addr !== 4'd0)
      $display("FAIL rm_src got %h want 0", src_addr);
    else passed++;
    total++;
    if ({bus.outValid, busy, done} !== 3'b000)
      $display("FAIL rm_flags got %b want 000",
        {bus.outValid, busy, done});
    else passed++;
    total++;
    if ({bus.outAddr, bus.outData} !== 20'h0)
      $display("FAIL rm_pair got %h want 0",
        {bus.outAddr, bus.outData});
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    scan(4'd0, 4'd1, 0, n, dc);
    total++;
    if (n !== 2) $display("FAIL rm_n got %0d want 2", n);
    else passed++;
    for (int i = 0; i < n && i < 2; i++) begin
      total++;
      if (got_a[i] !== 4'(i) || got_d[i] !== 16'hA000 + 16'(i))
        $display("FAIL rm_pair%0d got %h/%h want %h/%h", i,
          got_a[i], got_d[i], 4'(i), 16'hA000 + 16'(i));
      else passed++;
    end
    total++;
    if (dc !== 5) $display("FAIL rm_done got %0d want 5", dc);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
    bus.outReady = 1'b0;
    test_reset();
    test_full();
    test_wrap();
    test_single();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Sequential reader for the CPU register file. On a start pulse it walks a programmable address range on the register file's `srcAddr` read port, captures each word, and streams `{address, data}` pairs through a valid/ready interface. Downstream it feeds the debug path: UART dump, seven-segment display, or a bench checker. It uses only the read port, so it can run alongside normal writeback.

## Interface
- `WIDTH`, 16, register data width
- `REGBITS`, 4, address width; register count is 2^REGBITS
- `clk`  input  1  system clock, rising-edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle request to begin a scan; honoured only in IDLE
- `firstAddr`  input  REGBITS  first register of the scan; sampled when `start` is accepted
- `lastAddr`  input  REGBITS  last register of the scan; sampled when `start` is accepted
- `srcAddr`  output  REGBITS  read address driven to the register file
- `readData`  input  WIDTH  combinational read data from the register file for `srcAddr`
- `outValid`  output  1  `outAddr`/`outData` hold a pair
- `outReady`  input  1  consumer accepts the pair when `outValid && outReady`
- `outAddr`  output  REGBITS  register index of the current pair
- `outData`  output  WIDTH  captured register contents
- `busy`  output  1  high in FETCH or SEND
- `done`  output  1  one-cycle pulse after the last pair is accepted

## Operation
- The FSM has four states: IDLE, FETCH, SEND, DONE.
- IDLE
  - When `start`=1: latch `firstAddr` into the current-address register (`cur`) and `lastAddr` into `end`, then go to FETCH.
  - Otherwise stay in IDLE.
- FETCH
  - `srcAddr` = `cur`.
  - At the clock edge: `outData` <= `readData`, `outAddr` <= `cur`, `outValid` <= 1. Go to SEND.
- SEND
  - `outValid`, `outAddr` and `outData` stay stable until accepted.
  - On accept with `cur`==`end`: `outValid` <= 0, go to DONE.
  - On accept otherwise: `cur` <= `cur`+1 modulo 2^REGBITS, `outValid` <= 0, go to FETCH.
  - Without accept: stay in SEND.
- DONE
  - `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- Range and wrap-around
  - Number of pairs = ((`end` − `first`) mod 2^REGBITS) + 1.
  - `first`==`end` gives one pair.
  - `first`>`end` wraps: for example, 14..1 yields 14, 15, 0, 1.
- `start` is ignored in FETCH, SEND and DONE. It is not queued.
- `firstAddr` and `lastAddr` changing mid-scan have no effect.
- A register-file write during a scan is seen only if it lands before that register's FETCH edge. The scanner provides no snapshot.
- Reset, asserted at any time including mid-scan, forces IDLE immediately. All outputs go to 0: `srcAddr`, `outValid`, `outAddr`, `outData`, `busy`, `done`.
- In IDLE, `srcAddr` holds its last value. It is 0 after reset.

## Timing
- `start` sampled high at edge E0 puts FETCH in the cycle after E0, with `srcAddr`=`first`.
- `outValid` rises after E1, which gives a latency of 2 edges from `start` to the first valid pair.
- Steady state with `outReady` held at 1: one pair per 2 cycles.
- For an N-pair scan, the total time from the `start` edge to the `done` pulse is 2N+1 cycles with no backpressure.
- `outValid` never drops without an accept, except on reset.
- `busy` is registered-state decoded: high from the cycle after `start` is accepted through the cycle of the last accept. It is low during DONE.
- `done` and `busy` are never high together.

## Test plan
- Full scan: preload reg i = 16'hA000+i, `firstAddr`=0, `lastAddr`=15, `outReady`=1.
  - Expect 16 pairs in order (0, A000) … (15, A00F).
  - `done` pulses 33 cycles after the `start` edge.
- Wrap-around: `firstAddr`=14, `lastAddr`=1.
  - Expect pairs with addresses 14, 15, 0, 1, carrying data A00E, A00F, A000, A001.
  - Exactly 4 pairs, then a single `done` pulse.
- Single register: `firstAddr`=`lastAddr`=7.
  - Expect exactly one pair (7, A007).
  - `done` pulses 3 cycles after `start`.
- Backpressure: range 2..4, `outReady` held low for 5 cycles on each pair.
  - `outValid` and `outData` stay stable throughout each stall.
  - No pair is lost or duplicated.
  - `srcAddr` does not advance until the accept.
- `start` while busy: pulse `start` with `firstAddr`=9 during a 0..3 scan.
  - The scan still outputs exactly addresses 0–3.
  - No second scan follows, and the scanner returns to IDLE.
- Reset mid-scan: assert `reset` low during SEND of address 5 in a 0..15 scan.
  - All outputs go to 0 asynchronously.
  - A fresh `start` on range 0..1 then yields only (0, A000), (1, A001).
